alu_32bit: RTL and testbench
============================

Name: alu_32bit

Overview:
- Registered 32-bit ALU and zero/sign comparator for the single-cycle RISC datapath.
- Computes the result from two operands and a 4-bit op code.
- Classifies a separate compare operand (the rt register value) as zero, positive or negative for branch decisions.
- Result and flags are registered, giving one cycle of latency.

Parameters:
- WIDTH, 32, operand/result width. Only 32 is required to be supported.
- SHAMT_W, 5, number of low bits of operand b used as the shift amount.

Ports:
- write_clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands/op valid this cycle.
- a  input  32  operand 1 (rs, pc or sp).
- b  input  32  operand 2 (rt or sign-extended immediate).
- alu_op  input  4  operation select.
- cmp_in  input  32  value classified by the comparator.
- out_valid  output  1  result/flags valid.
- result  output  32  registered ALU result.
- eqz  output  1  cmp_in == 0.
- gz  output  1  cmp_in > 0, signed.
- lz  output  1  cmp_in < 0, signed.

Behaviour:
- Reset: on a rising edge with rst=1, out_valid=0, result=0, eqz=0, gz=0, lz=0. Reset has priority over in_valid.
- Latency: on each rising edge with rst=0:
  - out_valid <= in_valid.
  - If in_valid=1, result and flags load from the current inputs.
  - If in_valid=0, result and flags hold their previous values.
- No backpressure; a new operation can be accepted every cycle.
- alu_op encoding:
  - 0 ADD: a+b, mod 2^32, carry discarded.
  - 1 SUB: a-b, mod 2^32.
  - 2 AND: a&b.
  - 3 OR: a|b.
  - 4 XOR: a^b.
  - 5 NOT: ~a (b ignored).
  - 6 SLA: a << b[4:0], zero fill.
  - 7 SRA: a >>> b[4:0], sign fill from a[31].
  - 8 SRL: a >> b[4:0], zero fill.
  - 9 PASSB: b.
  - 10 PASSA: a.
  - 11-15: reserved; result=0.
- Shifts use only b[4:0]. b[31:5] is ignored, so b=33 shifts by 1. A shift amount of 0 returns a unchanged.
- Comparator: exactly one of eqz/gz/lz is 1 whenever loaded with in_valid=1. It is computed from cmp_in independently of alu_op.
- Wrap-around examples:
  - ADD 0x7FFFFFFF + 1 gives 0x80000000.
  - SUB 0 - 1 gives 0xFFFFFFFF.
- Reset mid-stream: an operation presented in the same cycle as rst is dropped; out_valid=0 on the next cycle.

Optional Feature:
- Macro ALU_STATUS_EN.
- When defined, three extra registered outputs are present, each 1 bit:
  - carry: carry-out of ADD; not-borrow of SUB (1 when a >= b unsigned).
  - ovf: signed overflow of ADD/SUB.
  - zero: result == 0.
- carry and ovf are 0 for all other ops.
- All three reset to 0 and load on the same edge as result.
- When not defined, these ports do not exist and behaviour is otherwise identical.

Decomposition:
- Package alu_pkg holds:
  - the alu_op enum (OP_ADD..OP_PASSA, values 0-10);
  - WIDTH and SHAMT_W constants.
- One natural sub-module, cmp_zero: a combinational classifier of a 32-bit value into eqz/gz/lz, instantiated once.
- The ALU datapath and the output registers stay in alu_32bit.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then in_valid=0 → out_valid=0, result=0, all flags 0.
- ADD wrap: a=0x7FFFFFFF, b=1, op=0 → next cycle result=0x80000000, out_valid=1. With ALU_STATUS_EN: ovf=1, carry=0.
- SUB / NOT:
  - a=5, b=7, op=1 → result=0xFFFFFFFE.
  - a=0x0F0F0F0F, op=5 → result=0xF0F0F0F0.
- Shifts with a=0x80000010:
  - op=7, b=4 → 0xF8000001.
  - op=8, b=4 → 0x08000001.
  - op=6, b=36 → 0x00000100 (shift by 4).
- Comparator with back-to-back valids: cmp_in=0, 5, 0xFFFFFFFF on three consecutive cycles → {eqz,gz,lz} = 100, 010, 001 on the following three cycles.
- Reserved op / hold / reset:
  - op=12 → result=0.
  - Then in_valid=0 → result holds 0 and out_valid=0.
  - rst asserted with in_valid=1, op=0, a=1, b=1 → result=0, out_valid=0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared constants and op-code encoding for the registered 32-bit ALU.
// Latency: n/a (declarations only). Backpressure: n/a.
package alu_pkg;

    localparam int WIDTH   = 32;
    localparam int SHAMT_W = 5;

    typedef enum logic [3:0] {
        OP_ADD   = 4'd0,
        OP_SUB   = 4'd1,
        OP_AND   = 4'd2,
        OP_OR    = 4'd3,
        OP_XOR   = 4'd4,
        OP_NOT   = 4'd5,
        OP_SLA   = 4'd6,
        OP_SRA   = 4'd7,
        OP_SRL   = 4'd8,
        OP_PASSB = 4'd9,
        OP_PASSA = 4'd10
    } alu_op_e;

endpackage

// File: rtl/cmp_zero.sv
// Classifies a two's-complement value as zero, positive or negative (one-hot).
// Latency: combinational. Backpressure: none.
module cmp_zero
    import alu_pkg::*;
(
    input  logic [WIDTH-1:0] i_val,
    output logic             o_eqz,
    output logic             o_gz,
    output logic             o_lz
);

    logic w_eqz;
    logic w_lz;

    assign w_eqz = ~|i_val;
    assign w_lz  = i_val[WIDTH-1];

    assign o_eqz = w_eqz;
    assign o_lz  = w_lz;
    assign o_gz  = ~w_eqz & ~w_lz;

endmodule

// File: rtl/alu_32bit.sv
// Registered 32-bit ALU plus rt zero/sign classifier; ALU_STATUS_EN adds carry/ovf/zero outputs.
// Latency: 1 cycle. Backpressure: none, one operation accepted per cycle; outputs hold while idle.
module alu_32bit
    import alu_pkg::*;
(
    input  logic             write_clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       alu_op,
    input  logic [WIDTH-1:0] cmp_in,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             eqz,
    output logic             gz,
    output logic             lz
`ifdef ALU_STATUS_EN
    ,
    output logic             carry,
    output logic             ovf,
    output logic             zero
`endif
);

    logic [SHAMT_W-1:0] w_shamt;
    logic [WIDTH-1:0]   w_res;
    logic [WIDTH-1:0]   w_sra;
    logic               w_eqz;
    logic               w_gz;
    logic               w_lz;

    logic               r_out_valid;
    logic [WIDTH-1:0]   r_result;
    logic               r_eqz;
    logic               r_gz;
    logic               r_lz;

    // Only the low bits of b steer the shifter; upper bits are ignored so b=33 shifts by 1.
    assign w_shamt = b[SHAMT_W-1:0];
    assign w_sra   = $signed(a) >>> w_shamt;

`ifdef ALU_STATUS_EN
    // Extra MSB captures carry-out of ADD and borrow of SUB.
    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_diff;
    logic           w_carry;
    logic           w_ovf;
    logic           r_carry;
    logic           r_ovf;
    logic           r_zero;

    assign w_sum  = {1'b0, a} + {1'b0, b};
    assign w_diff = {1'b0, a} - {1'b0, b};

    always_comb begin
        w_carry = 1'b0;
        w_ovf   = 1'b0;
        if (alu_op == OP_ADD) begin
            w_carry = w_sum[WIDTH];
            w_ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
        end else if (alu_op == OP_SUB) begin
            w_carry = ~w_diff[WIDTH];
            w_ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
        end
    end
`else
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_diff;

    assign w_sum  = a + b;
    assign w_diff = a - b;
`endif

    always_comb begin
        w_res = '0;
        case (alu_op)
            OP_ADD:   w_res = w_sum[WIDTH-1:0];
            OP_SUB:   w_res = w_diff[WIDTH-1:0];
            OP_AND:   w_res = a & b;
            OP_OR:    w_res = a | b;
            OP_XOR:   w_res = a ^ b;
            OP_NOT:   w_res = ~a;
            OP_SLA:   w_res = a << w_shamt;
            OP_SRA:   w_res = w_sra;
            OP_SRL:   w_res = a >> w_shamt;
            OP_PASSB: w_res = b;
            OP_PASSA: w_res = a;
            default:  w_res = '0;
        endcase
    end

    cmp_zero u_cmp_zero (
        .i_val (cmp_in),
        .o_eqz (w_eqz),
        .o_gz  (w_gz),
        .o_lz  (w_lz)
    );

    // Reset wins over in_valid, so an op presented alongside rst is dropped.
    always_ff @(posedge write_clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_eqz       <= 1'b0;
            r_gz        <= 1'b0;
            r_lz        <= 1'b0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_result <= w_res;
                r_eqz    <= w_eqz;
                r_gz     <= w_gz;
                r_lz     <= w_lz;
            end
        end
    end

`ifdef ALU_STATUS_EN
    always_ff @(posedge write_clk) begin
        if (rst) begin
            r_carry <= 1'b0;
            r_ovf   <= 1'b0;
            r_zero  <= 1'b0;
        end else if (in_valid) begin
            r_carry <= w_carry;
            r_ovf   <= w_ovf;
            r_zero  <= (w_res == '0);
        end
    end

    assign carry = r_carry;
    assign ovf   = r_ovf;
    assign zero  = r_zero;
`endif

    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign eqz       = r_eqz;
    assign gz        = r_gz;
    assign lz        = r_lz;

endmodule

// File: tb/tb_alu_32bit.sv
// Directed-vector bench for alu_32bit with hand-computed expected results and flags.
// Define ALU_STATUS_EN on both RTL and bench to also check carry/ovf/zero.
module tb_alu_32bit;

    logic        write_clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  alu_op;
    logic [31:0] cmp_in;
    logic        out_valid;
    logic [31:0] result;
    logic        eqz;
    logic        gz;
    logic        lz;
`ifdef ALU_STATUS_EN
    logic        carry;
    logic        ovf;
    logic        zero;
`endif

    int n_vec = 0;
    int n_err = 0;

    alu_32bit dut (
        .write_clk (write_clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .alu_op    (alu_op),
        .cmp_in    (cmp_in),
        .out_valid (out_valid),
        .result    (result),
        .eqz       (eqz),
        .gz        (gz),
        .lz        (lz)
`ifdef ALU_STATUS_EN
        ,
        .carry     (carry),
        .ovf       (ovf),
        .zero      (zero)
`endif
    );

    initial write_clk = 1'b0;
    always #5 write_clk = ~write_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Present one valid op, wait one edge, then check result, out_valid and {eqz,gz,lz}.
    task automatic run(input string tag, input logic [3:0] op, input logic [31:0] va,
                       input logic [31:0] vb, input logic [31:0] vc,
                       input logic [31:0] exp_res, input logic [2:0] exp_flags);
        alu_op   = op;
        a        = va;
        b        = vb;
        cmp_in   = vc;
        in_valid = 1'b1;
        @(posedge write_clk);
        #1;
        chk({tag, ".res"}, result, exp_res);
        chk({tag, ".vld"}, {31'd0, out_valid}, 32'd1);
        chk({tag, ".flg"}, {29'd0, eqz, gz, lz}, {29'd0, exp_flags});
    endtask

    task automatic idle_cycle();
        in_valid = 1'b0;
        a        = 32'hA5A5_A5A5;
        b        = 32'h5A5A_5A5A;
        alu_op   = 4'd0;
        cmp_in   = 32'h0000_0000;
        @(posedge write_clk);
        #1;
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        alu_op   = '0;
        cmp_in   = '0;
        repeat (2) @(posedge write_clk);
        #1;
        chk("rst.vld", {31'd0, out_valid}, 32'd0);
        chk("rst.res", result, 32'd0);
        chk("rst.flg", {29'd0, eqz, gz, lz}, 32'd0);
        rst = 1'b0;
        idle_cycle();
        chk("idle.vld", {31'd0, out_valid}, 32'd0);
        chk("idle.res", result, 32'd0);

        run("add_wrap", 4'd0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h0000_0000, 32'h8000_0000, 3'b100);
`ifdef ALU_STATUS_EN
        chk("add_wrap.cov", {29'd0, carry, ovf, zero}, {29'd0, 3'b010});
`endif
        run("add_carry", 4'd0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0009, 32'h0000_0000, 3'b010);
`ifdef ALU_STATUS_EN
        chk("add_carry.cov", {29'd0, carry, ovf, zero}, {29'd0, 3'b101});
`endif
        run("sub_neg", 4'd1, 32'h0000_0005, 32'h0000_0007, 32'h8000_0000, 32'hFFFF_FFFE, 3'b001);
`ifdef ALU_STATUS_EN
        chk("sub_neg.cov", {29'd0, carry, ovf, zero}, {29'd0, 3'b000});
`endif
        run("sub_zero", 4'd1, 32'h0000_0007, 32'h0000_0007, 32'h7FFF_FFFF, 32'h0000_0000, 3'b010);
`ifdef ALU_STATUS_EN
        chk("sub_zero.cov", {29'd0, carry, ovf, zero}, {29'd0, 3'b101});
`endif
        run("sub_wrap", 4'd1, 32'h0000_0000, 32'h0000_0001, 32'h0000_0000, 32'hFFFF_FFFF, 3'b100);
        run("not",  4'd5, 32'h0F0F_0F0F, 32'h1234_5678, 32'h0000_0000, 32'hF0F0_F0F0, 3'b100);
`ifdef ALU_STATUS_EN
        chk("not.cov", {29'd0, carry, ovf, zero}, {29'd0, 3'b000});
`endif
        run("and",  4'd2, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0000_0000, 32'h0F00_0F00, 3'b100);
        run("or",   4'd3, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0000_0000, 32'hFFF0_FFF0, 3'b100);
        run("xor",  4'd4, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0000_0000, 32'hF0F0_F0F0, 3'b100);
        run("sra4", 4'd7, 32'h8000_0010, 32'h0000_0004, 32'h0000_0000, 32'hF800_0001, 3'b100);
        run("srl4", 4'd8, 32'h8000_0010, 32'h0000_0004, 32'h0000_0000, 32'h0800_0001, 3'b100);
        run("sla36", 4'd6, 32'h8000_0010, 32'h0000_0024, 32'h0000_0000, 32'h0000_0100, 3'b100);
        run("srl33", 4'd8, 32'h8000_0010, 32'h0000_0021, 32'h0000_0000, 32'h4000_0008, 3'b100);
        run("srl0",  4'd8, 32'h8000_0010, 32'hFFFF_FFE0, 32'h0000_0000, 32'h8000_0010, 3'b100);
        run("sra31", 4'd7, 32'h8000_0010, 32'h0000_001F, 32'h0000_0000, 32'hFFFF_FFFF, 3'b100);
        run("passb", 4'd9, 32'hDEAD_BEEF, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 3'b100);

        // Back-to-back comparator loads with different ops; flags ignore alu_op.
        run("cmp0",  4'd10, 32'h0000_1234, 32'h0, 32'h0000_0000, 32'h0000_1234, 3'b100);
        run("cmp5",  4'd0,  32'h0000_0002, 32'h3, 32'h0000_0005, 32'h0000_0005, 3'b010);
        run("cmpm1", 4'd10, 32'hDEAD_BEEF, 32'h0, 32'hFFFF_FFFF, 32'hDEAD_BEEF, 3'b001);

        idle_cycle();
        chk("hold.res", result, 32'hDEAD_BEEF);
        chk("hold.vld", {31'd0, out_valid}, 32'd0);
        chk("hold.flg", {29'd0, eqz, gz, lz}, {29'd0, 3'b001});

        run("rsvd12", 4'd12, 32'h1111_1111, 32'h2222_2222, 32'h0000_0000, 32'h0000_0000, 3'b100);
        idle_cycle();
        chk("rsvd_hold.res", result, 32'h0000_0000);
        chk("rsvd_hold.vld", {31'd0, out_valid}, 32'd0);
        run("rsvd15", 4'd15, 32'h1111_1111, 32'h2222_2222, 32'h0000_0000, 32'h0000_0000, 3'b100);

        run("pre_rst", 4'd10, 32'hCAFE_F00D, 32'h0, 32'h0000_0001, 32'hCAFE_F00D, 3'b010);
        rst      = 1'b1;
        in_valid = 1'b1;
        alu_op   = 4'd0;
        a        = 32'h0000_0001;
        b        = 32'h0000_0001;
        cmp_in   = 32'h0000_0003;
        @(posedge write_clk);
        #1;
        chk("rst_mid.res", result, 32'h0000_0000);
        chk("rst_mid.vld", {31'd0, out_valid}, 32'd0);
        chk("rst_mid.flg", {29'd0, eqz, gz, lz}, 32'd0);
`ifdef ALU_STATUS_EN
        chk("rst_mid.cov", {29'd0, carry, ovf, zero}, 32'd0);
`endif
        rst = 1'b0;
        idle_cycle();
        chk("post_rst.vld", {31'd0, out_valid}, 32'd0);
        chk("post_rst.res", result, 32'h0000_0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
